branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//   Sequences branch comparison in the execute stage: accepts one conditional branch per handshake, drives
//   the comparator (BrUn from funct3), registers taken/target/mispredict, and flushes the front end on misprediction.
//   Owns a direct-mapped 2-bit BHT for fetch-stage prediction, plus branch and mispredict performance counters.
// PARAMETERS
//   XLEN        32  operand/PC width
//   BHT_IDX_W   4   BHT index width; entries = 2**BHT_IDX_W, indexed by pc[BHT_IDX_W+1:2]
//   CNT_W       16  performance counter width
// PORTS
//   clk            in   1         clock, all state updates on rising edge
//   rst_n          in   1         synchronous active-low reset
//   in_valid       in   1         branch op presented
//   in_ready       out  1         unit can accept op this cycle
//   in_funct3      in   3         RV32I branch funct3
//   in_src1        in   XLEN      rs1 value
//   in_src2        in   XLEN      rs2 value
//   in_pc          in   XLEN      branch PC
//   in_imm         in   XLEN      sign-extended B-immediate
//   in_pred_taken  in   1         prediction used by fetch for this branch
//   flush          in   1         kill from older instruction/trap
//   out_valid      out  1         registered result valid
//   out_ready      in   1         consumer accepts result
//   out_taken      out  1         branch resolved taken
//   out_target     out  XLEN      next PC: taken ? pc+imm : pc+4
//   out_mispredict out  1         out_taken != in_pred_taken (captured)
//   out_illegal    out  1         funct3 was 010/011
//   pred_pc        in   XLEN      fetch-stage lookup PC
//   pred_taken     out  1         BHT prediction for pred_pc (combinational)
//   br_count       out  CNT_W     retired branch count
//   mispred_count  out  CNT_W     retired mispredict count
// BEHAVIOUR
//   Reset (rst_n=0 at edge): out_valid=0, out_taken=0, out_target=0, out_mispredict=0, out_illegal=0,
//     br_count=0, mispred_count=0, every BHT entry=2'b01 (weakly not-taken). Reset mid-operation drops in-flight result.
//   Handshake: in_ready = !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
//     Output fire = out_valid && out_ready && !flush. Outputs held stable while out_valid && !out_ready.
//   Latency: 1 cycle; op accepted at edge N -> out_valid high after edge N. Back-to-back throughput 1/cycle when out_ready=1.
//   Compare: BrUn = funct3[1]; BrEq = src1==src2; BrLT = BrUn ? unsigned lt : signed lt.
//   Taken: 000 BEQ=Eq, 001 BNE=!Eq, 100 BLT=LT, 101 BGE=!LT, 110 BLTU=LT, 111 BGEU=!LT.
//     010/011: taken=0, illegal=1, target=pc+4, mispredict=pred_taken; counters and BHT not updated.
//   Target arithmetic modulo 2**XLEN (wrap, no overflow flag).
//   Output register FSM: EMPTY (out_valid=0) / FULL (out_valid=1).
//     EMPTY: accept -> FULL. FULL: fire && accept -> FULL (new op); fire && !accept -> EMPTY; !fire -> FULL.
//     flush in any state -> EMPTY next edge, no accept, no BHT/counter update.
//   BHT update on fire of legal op: idx = captured pc[BHT_IDX_W+1:2]; taken -> counter+1 saturating at 11,
//     not-taken -> counter-1 saturating at 00.
//   pred_taken = bht[pred_pc[BHT_IDX_W+1:2]][1]; same-cycle update to same index: lookup returns pre-update value.
//   On fire of legal op: br_count+1; mispred_count+1 if out_mispredict. Both wrap at 2**CNT_W.
// TESTING
//   Reset: hold rst_n=0 2 cycles -> out_valid=0, counters 0, pred_taken=0 for every pred_pc.
//   BLT src1=0xFFFFFFFF, src2=1, pc=0x100, imm=0x20 -> taken=1, target=0x120; BLTU same operands -> taken=0, target=0x104.
//   BEQ 5==5 pred_taken=0, out_ready=1 -> out_mispredict=1, mispred_count=1, bht[0] 01->10, pred_taken(pc=0x100)=1 next cycle.
//   out_ready=0 for 3 cycles with second op pending -> in_ready=0, outputs unchanged; release -> second result next cycle.
//   flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, counters/BHT unchanged, input not accepted.
//   funct3=010 -> out_illegal=1, br_count unchanged; pc=0xFFFFFFFC, imm=8 taken -> target=0x00000004.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// ============================================================================
// branch_resolve_unit_if : issue/result/predict bundle for branch_resolve_unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic             in_pred_taken;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic             out_mispredict;
  logic             out_illegal;
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output in_valid, in_funct3, in_src1, in_src2, in_pc, in_imm, in_pred_taken,
    output flush, out_ready, pred_pc,
    input  in_ready, out_valid, out_taken, out_target, out_mispredict, out_illegal,
    input  pred_taken, br_count, mispred_count
  );

  modport slave (
    input  in_valid, in_funct3, in_src1, in_src2, in_pc, in_imm, in_pred_taken,
    input  flush, out_ready, pred_pc,
    output in_ready, out_valid, out_taken, out_target, out_mispredict, out_illegal,
    output pred_taken, br_count, mispred_count
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit : execute-stage branch compare, 2-bit BHT, perf counters
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bru
);
  localparam int          BHT_ENTRIES = 2 ** BHT_IDX_W;
  localparam logic [0:0]  S_EMPTY     = 1'b0;
  localparam logic [0:0]  S_FULL      = 1'b1;

  logic [0:0]                       state_q, state_d;
  logic                             taken_q, taken_d;
  logic [XLEN-1:0]                  target_q, target_d;
  logic                             mispred_q, mispred_d;
  logic                             illegal_q, illegal_d;
  logic [BHT_IDX_W-1:0]             idx_q, idx_d;
  logic [BHT_ENTRIES-1:0][1:0]      bht_q, bht_d;
  logic [CNT_W-1:0]                 br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]                 mp_cnt_q, mp_cnt_d;

  logic            w_out_valid, w_in_ready, w_accept, w_fire;
  logic            w_eq, w_lt, w_taken, w_illegal;
  logic [XLEN-1:0] w_target;

  assign w_out_valid = (state_q == S_FULL);
  assign w_in_ready  = !bru.flush && (!w_out_valid || bru.out_ready);
  assign w_accept    = bru.in_valid && w_in_ready;
  assign w_fire      = w_out_valid && bru.out_ready && !bru.flush;

  // funct3[1] selects unsigned compare (BLTU/BGEU)
  assign w_eq = (bru.in_src1 == bru.in_src2);
  assign w_lt = bru.in_funct3[1] ? (bru.in_src1 < bru.in_src2)
                                 : ($signed(bru.in_src1) < $signed(bru.in_src2));

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (bru.in_funct3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = !w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      3'b110:  w_taken = w_lt;
      3'b111:  w_taken = !w_lt;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_target = w_taken ? (bru.in_pc + bru.in_imm)
                            : (bru.in_pc + {{(XLEN-3){1'b0}}, 3'd4});

  always_comb begin
    state_d   = state_q;
    taken_d   = taken_q;
    target_d  = target_q;
    mispred_d = mispred_q;
    illegal_d = illegal_q;
    idx_d     = idx_q;
    bht_d     = bht_q;
    br_cnt_d  = br_cnt_q;
    mp_cnt_d  = mp_cnt_q;

    if (w_fire && !illegal_q) begin
      br_cnt_d = br_cnt_q + 1'b1;
      if (mispred_q) mp_cnt_d = mp_cnt_q + 1'b1;
      if (taken_q) begin
        if (bht_q[idx_q] != 2'b11) bht_d[idx_q] = bht_q[idx_q] + 2'd1;
      end else begin
        if (bht_q[idx_q] != 2'b00) bht_d[idx_q] = bht_q[idx_q] - 2'd1;
      end
    end

    if (bru.flush) begin
      state_d = S_EMPTY;
    end else if (w_accept) begin
      state_d   = S_FULL;
      taken_d   = w_taken;
      target_d  = w_target;
      mispred_d = (w_taken != bru.in_pred_taken);
      illegal_d = w_illegal;
      idx_d     = bru.in_pc[BHT_IDX_W+1:2];
    end else if (w_fire) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      taken_q   <= 1'b0;
      target_q  <= '0;
      mispred_q <= 1'b0;
      illegal_q <= 1'b0;
      idx_q     <= '0;
      bht_q     <= {BHT_ENTRIES{2'b01}};
      br_cnt_q  <= '0;
      mp_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      mispred_q <= mispred_d;
      illegal_q <= illegal_d;
      idx_q     <= idx_d;
      bht_q     <= bht_d;
      br_cnt_q  <= br_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
    end
  end

  assign bru.in_ready       = w_in_ready;
  assign bru.out_valid      = w_out_valid;
  assign bru.out_taken      = taken_q;
  assign bru.out_target     = target_q;
  assign bru.out_mispredict = mispred_q;
  assign bru.out_illegal    = illegal_q;
  assign bru.br_count       = br_cnt_q;
  assign bru.mispred_count  = mp_cnt_q;
  // lookup sees the pre-update table when fetch and retire hit the same index
  assign bru.pred_taken     = bht_q[bru.pred_pc[BHT_IDX_W+1:2]][1];

  logic w_unused_pred_pc;
  assign w_unused_pred_pc = &{1'b0, bru.pred_pc[XLEN-1:BHT_IDX_W+2], bru.pred_pc[1:0]};

endmodule

`default_nettype wire
